multicycle_control: RTL

- Moore-style FSM that sequences a multi-cycle MIPS datapath.
- Datapath resources: shared instruction/data memory, single ALU, PC register, instruction register (IR) and register file.
- Decodes the IR opcode, issues per-state control strobes, stalls on a memory-ready handshake and traps on illegal opcodes or memory timeout.
- Sits between the instruction register and the datapath muxes/enables, replacing the single-cycle Control block.

---
 rtl/mips_ctrl_pkg.sv | 75 +++++++
 rtl/multicycle_control_if.sv | 37 +++
 rtl/ctrl_word_decode.sv | 104 ++++++++++
 rtl/multicycle_control.sv | 118 +++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, state encodings and control-field codes for the multi-cycle
// MIPS controller.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_JUMP   = 4'd12,
    ST_TRAP   = 4'd15
  } state_t;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] REGDST_RT    = 2'b00;
  localparam logic [1:0] REGDST_RD    = 2'b01;
  localparam logic [1:0] REGDST_RA    = 2'b10;

  localparam logic [1:0] MTR_ALUOUT   = 2'b00;
  localparam logic [1:0] MTR_MDR      = 2'b01;
  localparam logic [1:0] MTR_PC       = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       trap;
  } ctrl_word_t;

  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller (master) and the
// datapath it steers (slave).
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       Branch;
  logic       BranchNe;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] MemtoReg;
  logic [1:0] RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       trap;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, Branch, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, trap, state_dbg
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, Branch, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, trap, state_dbg
  );
endinterface

// File: rtl/ctrl_word_decode.sv
// Moore decode of the controller state into datapath strobes; only the FETCH
// loads and the MEMWR retire also look at mem_ready.
module ctrl_word_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       op_bit0,
  input  logic       mem_ready,
  output ctrl_word_t ctrl
);

  // Per-state control word; anything not named stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
        end else begin
          ctrl.ir_write = 1'b0;
          ctrl.pc_write = 1'b0;
        end
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR, ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = MTR_MDR;
        ctrl.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RD;
        ctrl.mem_to_reg = MTR_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      // beq and bne differ only in opcode bit 0
      ST_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_source  = PCSRC_ALUOUT;
        ctrl.branch     = ~op_bit0;
        ctrl.branch_ne  = op_bit0;
        ctrl.instr_done = 1'b1;
      end
      ST_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = MTR_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      // j and jal likewise; jal also links into r31
      ST_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
        if (op_bit0) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = REGDST_RA;
          ctrl.mem_to_reg = MTR_PC;
        end else begin
          ctrl.reg_write  = 1'b0;
          ctrl.reg_dst    = REGDST_RT;
          ctrl.mem_to_reg = MTR_ALUOUT;
        end
      end
      ST_TRAP: begin
        ctrl.trap = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: state register, opcode-driven next-state logic
// and a memory-wait watchdog that traps on a stalled handshake.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master ctl
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             timed_out_s;
  ctrl_word_t       ctrl_s;

  assign timed_out_s = (wait_cnt_r == TIMEOUT_C);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; mem_ready beats the timeout in the same cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: state_next_s = ST_FETCH;
      ST_FETCH: begin
        if (ctl.mem_ready)     state_next_s = ST_DECODE;
        else if (timed_out_s)  state_next_s = ST_TRAP;
        else                   state_next_s = ST_FETCH;
      end
      ST_DECODE: begin
        case (ctl.opcode)
          OP_RTYPE:       state_next_s = ST_EXEC;
          OP_LW, OP_SW:   state_next_s = ST_MEMADR;
          OP_BEQ, OP_BNE: state_next_s = ST_BRANCH;
          OP_ADDI:        state_next_s = ST_ADDIEX;
          OP_J, OP_JAL:   state_next_s = ST_JUMP;
          default:        state_next_s = ST_TRAP;
        endcase
      end
      ST_MEMADR: begin
        if (ctl.opcode == OP_LW)      state_next_s = ST_MEMRD;
        else if (ctl.opcode == OP_SW) state_next_s = ST_MEMWR;
        else                          state_next_s = ST_TRAP;
      end
      ST_MEMRD: begin
        if (ctl.mem_ready)     state_next_s = ST_MEMWB;
        else if (timed_out_s)  state_next_s = ST_TRAP;
        else                   state_next_s = ST_MEMRD;
      end
      ST_MEMWR: begin
        if (ctl.mem_ready)     state_next_s = ST_FETCH;
        else if (timed_out_s)  state_next_s = ST_TRAP;
        else                   state_next_s = ST_MEMWR;
      end
      ST_EXEC:   state_next_s = ST_ALUWB;
      ST_ADDIEX: state_next_s = ST_ADDIWB;
      ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_ADDIWB, ST_JUMP: state_next_s = ST_FETCH;
      ST_TRAP:   state_next_s = ST_TRAP;
      default:   state_next_s = ST_TRAP;
    endcase
  end

  // Wait-cycle counter: zeroed on every state change, saturating count of not-ready cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_next_s != state_r) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (is_wait_state(state_r) && !ctl.mem_ready && !timed_out_s) begin
      wait_cnt_r <= wait_cnt_r + CNT_ONE;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  ctrl_word_decode u_decode (
    .state     (state_r),
    .op_bit0   (ctl.opcode[0]),
    .mem_ready (ctl.mem_ready),
    .ctrl      (ctrl_s)
  );

  // Output process: drive the bundle from the decoded control word.
  always_comb begin
    ctl.PCWrite    = ctrl_s.pc_write;
    ctl.Branch     = ctrl_s.branch;
    ctl.BranchNe   = ctrl_s.branch_ne;
    ctl.IorD       = ctrl_s.i_or_d;
    ctl.MemRead    = ctrl_s.mem_read;
    ctl.MemWrite   = ctrl_s.mem_write;
    ctl.IRWrite    = ctrl_s.ir_write;
    ctl.MemtoReg   = ctrl_s.mem_to_reg;
    ctl.RegDst     = ctrl_s.reg_dst;
    ctl.RegWrite   = ctrl_s.reg_write;
    ctl.ALUSrcA    = ctrl_s.alu_src_a;
    ctl.ALUSrcB    = ctrl_s.alu_src_b;
    ctl.ALUOp      = ctrl_s.alu_op;
    ctl.PCSource   = ctrl_s.pc_source;
    ctl.instr_done = ctrl_s.instr_done;
    ctl.trap       = ctrl_s.trap;
    ctl.state_dbg  = state_r;
  end

endmodule
